lshift_rot_sched: RTL and testbench

Shares one rotate-left shift register between NREQ requesters. Each requester submits a load value and a rotate amount. The block arbitrates round-robin, loads the register, rotates it one bit per cycle for the requested amount, then returns the result on a valid/ready response port tagged with the requester ID. It sits between client blocks and the shift-register datapath and is the only writer of that register.

---
 rtl/lshift_rot_pkg.sv | 42 ++++
 rtl/lshift_rot_sched_rot_reg_core.sv | 41 ++++
 rtl/lshift_rot_sched.sv | 184 ++++++++++++++++++
 tb/tb_lshift_rot_sched.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lshift_rot_pkg.sv
`default_nettype none
// ============================================================================
// Module : lshift_rot_pkg
// Brief  : Shared types, defaults and the round-robin pick helper for the
//          lshift_rot_sched shared rotate-register scheduler.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Contents:
//   state_t   scheduler FSM states (IDLE, ROT, RESP)
//   DEF_*     default parameter values
//   rr_pick   round-robin winner search over up to 8 requesters
// ============================================================================
package lshift_rot_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AMT_W = 3;
  localparam int DEF_NREQ  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    RESP = 2'd2
  } state_t;

  // First asserted valid bit at or above ptr, wrapping around. The search
  // wraps modulo 8; callers zero-pad valid above NREQ and keep ptr < NREQ,
  // which makes this identical to a modulo-NREQ search.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr);
    logic [2:0] idx;
    logic [2:0] pick;
    pick = ptr;
    // Descending scan so the smallest offset from ptr is written last.
    for (int i = 7; i >= 0; i--) begin
      idx = ptr + 3'(i);
      if (valid[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lshift_rot_sched_rot_reg_core.sv
`default_nettype none
// ============================================================================
// Module : rot_reg_core
// Brief  : WIDTH-bit rotate register with load, rotate-enable, direction and
//          synchronous clear.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk       in   clock, rising edge
//   clr       in   synchronous clear (highest priority)
//   load      in   load load_val (priority over rotate)
//   load_val  in   WIDTH value to load
//   rot_en    in   rotate by one bit this cycle
//   dir       in   0 = rotate left, 1 = rotate right
//   q         out  register contents
// ============================================================================
module rot_reg_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             rot_en,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (rot_en) begin
      if (dir) q <= {q[0], q[WIDTH-1:1]};
      else     q <= {q[WIDTH-2:0], q[WIDTH-1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/lshift_rot_sched.sv
`default_nettype none
// ============================================================================
// Module : lshift_rot_sched
// Brief  : Round-robin scheduler sharing one rotate register among NREQ
//          requesters. Accepts one job, rotates it one bit per cycle for the
//          requested amount, and returns the result tagged with the owner ID.
// Rev    : 1.0  initial release
// Option : LSHIFT_ROT_SCHED_DIR_EN adds req_dir (per-requester direction,
//          0 = left, 1 = right); without it every job rotates left.
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   synchronous active-low reset
//   req_valid  in   NREQ        per-requester request valid
//   req_ready  out  NREQ        accept strobe, one-hot or zero
//   req_data   in   NREQ*WIDTH  load values, slice k*WIDTH
//   req_amt    in   NREQ*AMT_W  rotate amounts, slice k*AMT_W
//   req_dir    in   NREQ        rotate direction (optional)
//   rsp_valid  out  1           result valid
//   rsp_ready  in   1           consumer accepts result
//   rsp_data   out  WIDTH       rotated result
//   rsp_id     out  ID_W        owner of rsp_data
//   busy       out  1           state is not IDLE
// ============================================================================
module lshift_rot_sched
  import lshift_rot_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int AMT_W = DEF_AMT_W,
  parameter int ID_W  = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ*AMT_W-1:0] req_amt,
`ifdef LSHIFT_ROT_SCHED_DIR_EN
  input  logic [NREQ-1:0]       req_dir,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy
);

  state_t           state;
  state_t           state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  rsp_id_q;
  logic [AMT_W-1:0] cnt;
  logic [7:0]       valid_pad;
  logic [2:0]       ptr_pad;
  logic [2:0]       win;
  logic             any_valid;
  logic [WIDTH-1:0] sel_data;
  logic [AMT_W-1:0] sel_amt;
  logic             accept;
  logic             rot_en;
  logic             clr;
  logic             dir_q;
  logic [WIDTH-1:0] reg_q;

  // ---------------------------------------------------------------- arbiter
  always_comb begin
    valid_pad             = '0;
    valid_pad[NREQ-1:0]   = req_valid;
    ptr_pad               = 3'(ptr);
  end

  assign any_valid = |req_valid;
  assign win       = rr_pick(valid_pad, ptr_pad);

  // Winner's payload; a compare-per-requester mux keeps index widths exact.
  always_comb begin
    sel_data = '0;
    sel_amt  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == 3'(k)) begin
        sel_data = req_data[k*WIDTH +: WIDTH];
        sel_amt  = req_amt[k*AMT_W +: AMT_W];
      end
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    rot_en    = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          for (int k = 0; k < NREQ; k++) begin
            req_ready[k] = (win == 3'(k));
          end
          accept    = 1'b1;
          state_nxt = (sel_amt == '0) ? RESP : ROT;
        end
      end
      ROT: begin
        rot_en = 1'b1;
        if (cnt == AMT_W'(1)) state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Nothing is granted while reset is being applied.
    if (!rstn) begin
      req_ready = '0;
      accept    = 1'b0;
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt      <= '0;
      ptr      <= '0;
      rsp_id_q <= '0;
    end else begin
      if (accept) begin
        cnt      <= sel_amt;
        rsp_id_q <= ID_W'(win);
      end else if (rot_en) begin
        cnt <= cnt - AMT_W'(1);
      end
      // Pointer moves past the requester just served, modulo NREQ.
      if (state == RESP && rsp_ready) begin
        if (rsp_id_q == ID_W'(NREQ - 1)) ptr <= '0;
        else                             ptr <= rsp_id_q + ID_W'(1);
      end
    end
  end

`ifdef LSHIFT_ROT_SCHED_DIR_EN
  logic sel_dir;

  always_comb begin
    sel_dir = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (win == 3'(k)) sel_dir = req_dir[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)       dir_q <= 1'b0;
    else if (accept) dir_q <= sel_dir;
  end
`else
  assign dir_q = 1'b0;
`endif

  assign clr = ~rstn;

  rot_reg_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .clr      (clr),
    .load     (accept),
    .load_val (sel_data),
    .rot_en   (rot_en),
    .dir      (dir_q),
    .q        (reg_q)
  );

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign rsp_data  = reg_q;
  assign rsp_id    = rsp_id_q;

endmodule
`default_nettype wire

// File: tb/tb_lshift_rot_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_lshift_rot_sched
// Brief  : Self-checking bench for lshift_rot_sched (3 requesters, 4-bit
//          amounts so rotations beyond WIDTH occur). A transaction-level model
//          tracks the in-flight job, arbitration pointer and response timing.
// Rev    : 1.0  initial release
// ============================================================================
module tb_lshift_rot_sched;

  localparam int W  = 8;
  localparam int N  = 3;
  localparam int AW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rstn;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_data;
  logic [N*AW-1:0] req_amt;
  logic [N-1:0]    req_dir;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_data;
  logic [IW-1:0]   rsp_id;
  logic            busy;

  lshift_rot_sched #(.WIDTH(W), .NREQ(N), .AMT_W(AW), .ID_W(IW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
`ifdef LSHIFT_ROT_SCHED_DIR_EN
    .req_dir   (req_dir),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference rotation: plain arithmetic on the amount modulo the width.
  function automatic logic [7:0] ref_rot(input logic [7:0] d, input int amt, input bit right);
    int s;
    int v;
    s = amt % W;
    if (right) s = (W - s) % W;
    v = int'(d);
    return 8'(((v << s) | (v >> (W - s))) & 255);
  endfunction

  // ---------------------------------------------------------------- model
  bit         m_busy = 0;
  int         m_ptr = 0;
  int         j_id, j_amt, j_cyc;
  logic [7:0] j_data;
  bit         j_dir;
  int         cyc = 0;
  int         rsp_cnt = 0;
  int         last_lat;
  logic [7:0] last_data;
  int         last_id;
  bit         chk_zero = 0;
  bit [N-1:0] acc_flag = '0;
  int         acc_order[$];

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    int           w;
    bit           exp_v;
    if (chk_zero) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk_zero = 0;
    end
    if (!rstn) begin
      chk("ready_in_rst", req_ready, 0);
      m_busy   = 0;
      m_ptr    = 0;
      chk_zero = 1;
    end else begin
      exp_ready = '0;
      w = -1;
      if (!m_busy) begin
        for (int i = 0; i < N; i++) begin
          if (w < 0 && req_valid[(m_ptr + i) % N]) w = (m_ptr + i) % N;
        end
        if (w >= 0) exp_ready[w] = 1'b1;
      end
      chk("req_ready", req_ready, exp_ready);
      chk("busy", busy, m_busy);
      if (m_busy) begin
        exp_v = (cyc >= j_cyc + 1 + j_amt);
        chk("rsp_valid", rsp_valid, exp_v);
        if (exp_v) begin
          chk("rsp_data", rsp_data, ref_rot(j_data, j_amt, j_dir));
          chk("rsp_id", rsp_id, j_id);
          if (rsp_ready) begin
            m_busy    = 0;
            m_ptr     = (j_id + 1) % N;
            last_lat  = cyc - j_cyc;
            last_data = rsp_data;
            last_id   = int'(rsp_id);
            rsp_cnt++;
          end
        end
      end else if (w >= 0) begin
        j_id   = w;
        j_data = req_data[w*W +: W];
        j_amt  = int'(req_amt[w*AW +: AW]);
`ifdef LSHIFT_ROT_SCHED_DIR_EN
        j_dir  = req_dir[w];
`else
        j_dir  = 1'b0;
`endif
        j_cyc  = cyc;
        m_busy = 1;
        acc_flag[w] = 1'b1;
        acc_order.push_back(w);
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------- driver
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc_flag[k]) begin
        req_valid[k] = 1'b0;
        acc_flag[k]  = 1'b0;
      end
    end
  endtask

  task automatic set_req(input int k, input logic [7:0] d, input int a, input bit dir);
    req_valid[k]        = 1'b1;
    req_data[k*W +: W]  = d;
    req_amt[k*AW +: AW] = AW'(a);
    req_dir[k]          = dir;
  endtask

  task automatic wait_rsp(input int target, input int limit);
    int t = 0;
    while (rsp_cnt < target && t < limit) begin
      tick();
      t++;
    end
    if (rsp_cnt < target) chk("timeout", rsp_cnt, target);
  endtask

  task automatic wait_idle(input int limit);
    int t = 0;
    while ((m_busy || req_valid != '0) && t < limit) begin
      tick();
      t++;
    end
    if (m_busy || req_valid != '0) chk("idle_timeout", {31'd0, m_busy}, 0);
  endtask

  initial begin
    int base;
    rstn      = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_amt   = '0;
    req_dir   = '0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Basic rotate: A5 rol 3 = 2D, response four cycles after accept.
    base = rsp_cnt;
    set_req(0, 8'hA5, 3, 0);
    wait_rsp(base + 1, 30);
    chk("basic_data", last_data, 8'h2D);
    chk("basic_id", last_id, 0);
    chk("basic_lat", last_lat, 4);

    // Zero amount: passes through one cycle after accept.
    base = rsp_cnt;
    set_req(1, 8'h3C, 0, 0);
    wait_rsp(base + 1, 30);
    chk("zero_data", last_data, 8'h3C);
    chk("zero_id", last_id, 1);
    chk("zero_lat", last_lat, 1);

    // Amount above WIDTH: 12 rotations of 96 = rol 4 = 69.
    base = rsp_cnt;
    set_req(2, 8'h96, 12, 0);
    wait_rsp(base + 1, 40);
    chk("big_amt_data", last_data, 8'h69);
    chk("big_amt_lat", last_lat, 13);
    wait_idle(10);

    // Round-robin between two continuously requesting clients.
    acc_order.delete();
    for (int t = 0; t < 80 && acc_order.size() < 4; t++) begin
      for (int k = 0; k < 2; k++)
        if (!req_valid[k]) set_req(k, 8'($urandom), $urandom_range(0, 3), 0);
      tick();
    end
    req_valid = '0;
    chk("rr_count", acc_order.size(), 4);
    if (acc_order.size() >= 4) begin
      chk("rr_order0", acc_order[0], 0);
      chk("rr_order1", acc_order[1], 1);
      chk("rr_order2", acc_order[2], 0);
      chk("rr_order3", acc_order[3], 1);
    end
    wait_idle(40);

    // Backpressure: response held five cycles, pending request waits.
    base = rsp_cnt;
    rsp_ready = 1'b0;
    set_req(0, 8'h5A, 2, 0);
    tick();
    set_req(1, 8'hC3, 1, 0);
    for (int t = 0; t < 20 && !rsp_valid; t++) tick();
    repeat (5) tick();
    chk("bp_hold_data", rsp_data, ref_rot(8'h5A, 2, 0));
    chk("bp_no_accept", acc_flag, 0);
    rsp_ready = 1'b1;
    wait_rsp(base + 2, 30);
    chk("bp_second_id", last_id, 1);
    wait_idle(10);

    // Reset in the middle of a long rotation, then a clean job.
    set_req(0, 8'hF0, 7, 0);
    repeat (3) tick();
    chk("mid_busy", busy, 1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    base = rsp_cnt;
    tick();
    chk("post_rst_cnt", rsp_cnt, base);
    acc_order.delete();
    set_req(0, 8'hF0, 7, 0);
    wait_rsp(base + 1, 30);
    chk("post_rst_data", last_data, 8'h78);
    chk("post_rst_lat", last_lat, 8);
    wait_idle(10);

`ifdef LSHIFT_ROT_SCHED_DIR_EN
    base = rsp_cnt;
    set_req(0, 8'h01, 1, 1);
    wait_rsp(base + 1, 30);
    chk("dir_right", last_data, 8'h80);
    set_req(1, 8'h81, 2, 0);
    wait_rsp(base + 2, 30);
    chk("dir_left", last_data, 8'h06);
    wait_idle(10);
`endif

    // Randomised traffic with backpressure, request drops and resets.
    for (int t = 0; t < 2000; t++) begin
      for (int k = 0; k < N; k++) begin
        if (!req_valid[k]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(k, 8'($urandom), $urandom_range(0, 15), 1'($urandom));
        end else if ($urandom_range(0, 24) == 0) begin
          req_valid[k] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rstn      = ($urandom_range(0, 299) != 0);
      tick();
    end
    rstn      = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '0;
    wait_idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
